seg7_scan8: RTL and testbench

- Downstream display stage for the switch/decoder lab blocks.
- Time-multiplexes eight 4-bit digit values onto one shared active-low 7-segment bus plus eight active-low anode lines.
- Replaces the fixed single-digit anode drive with a refresh scanner that includes per-digit blanking, decimal points, tear-free frame snapshots and anti-ghosting dead time.

---
 rtl/seg7_scan8.sv | 118 +++++++++++
 tb/tb_seg7_scan8.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan8.sv
// rtl/seg7_scan8.sv - eight-digit multiplexed 7-segment scanner with frame snapshots and anode dead time
// Digits are latched once per frame so a whole frame always shows one consistent set of inputs.

module seg7_scan8 #(
    parameter int PRESCALE  = 12500,
    parameter int BLANK_CYC = 250,
    parameter bit HEX_MODE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dig_en,
    input  logic [7:0]  dp,
    output logic [6:0]  HEX0,
    output logic        DP,
    output logic [7:0]  AN,
    output logic        frame_start
);

    localparam logic [15:0] CNT_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] snap_digits_q, snap_digits_d;
    logic [7:0]  snap_en_q, snap_en_d;
    logic [7:0]  snap_dp_q, snap_dp_d;
    logic        first_pending_q, first_pending_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  hex_q, hex_d;
    logic        dp_q, dp_d;
    logic        frame_start_q, frame_start_d;

    logic        tick;
    logic        load;
    logic [3:0]  cur_val;
    logic        cur_en;

    // Active-low glyphs, bit order g..a.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        g = 7'b1111111;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = HEX_MODE ? 7'b0001000 : 7'b1111111;
            4'hB: g = HEX_MODE ? 7'b0000011 : 7'b1111111;
            4'hC: g = HEX_MODE ? 7'b1000110 : 7'b1111111;
            4'hD: g = HEX_MODE ? 7'b0100001 : 7'b1111111;
            4'hE: g = HEX_MODE ? 7'b0000110 : 7'b1111111;
            4'hF: g = HEX_MODE ? 7'b0001110 : 7'b1111111;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;

        // Reload on the last cycle of digit 7 so digit 0 of the next slot already sees the new frame.
        load            = (tick && (idx_q == 3'd7)) || first_pending_q;
        snap_digits_d   = load ? digits : snap_digits_q;
        snap_en_d       = load ? dig_en : snap_en_q;
        snap_dp_d       = load ? dp     : snap_dp_q;
        first_pending_d = 1'b0;
        frame_start_d   = load;

        cur_val = snap_digits_q[{idx_q, 2'b00} +: 4];
        cur_en  = snap_en_q[idx_q];

        // The first BLANK_CYC cycles of every slot keep all anodes dark to stop ghosting.
        an_d  = (cur_en && (cnt_q >= BLANK_END)) ? ~(8'b1 << idx_q) : 8'hFF;
        hex_d = cur_en ? glyph(cur_val) : 7'h7F;
        dp_d  = cur_en ? ~snap_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= 16'd0;
            idx_q           <= 3'd0;
            snap_digits_q   <= 32'd0;
            snap_en_q       <= 8'd0;
            snap_dp_q       <= 8'd0;
            first_pending_q <= 1'b1;
            an_q            <= 8'hFF;
            hex_q           <= 7'h7F;
            dp_q            <= 1'b1;
            frame_start_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            snap_digits_q   <= snap_digits_d;
            snap_en_q       <= snap_en_d;
            snap_dp_q       <= snap_dp_d;
            first_pending_q <= first_pending_d;
            an_q            <= an_d;
            hex_q           <= hex_d;
            dp_q            <= dp_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign HEX0        = hex_q;
    assign DP          = dp_q;
    assign AN          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan8.sv
// tb/tb_seg7_scan8.sv - self-checking bench for seg7_scan8 (both HEX_MODE settings side by side)

module tb_seg7_scan8;

    localparam int PS    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 8 * PS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_digits = '0;
    logic [7:0]  in_en = '0;
    logic [7:0]  in_dp = '0;

    logic [6:0]  hex_h, hex_d;
    logic        dp_h, dp_d;
    logic [7:0]  an_h, an_d;
    logic        fs_h, fs_d;

    seg7_scan8 #(.PRESCALE(PS), .BLANK_CYC(BC), .HEX_MODE(1'b1)) u_hex (
        .clk(clk), .rst(rst), .digits(in_digits), .dig_en(in_en), .dp(in_dp),
        .HEX0(hex_h), .DP(dp_h), .AN(an_h), .frame_start(fs_h)
    );

    seg7_scan8 #(.PRESCALE(PS), .BLANK_CYC(BC), .HEX_MODE(1'b0)) u_dec (
        .clk(clk), .rst(rst), .digits(in_digits), .dig_en(in_en), .dp(in_dp),
        .HEX0(hex_d), .DP(dp_d), .AN(an_d), .frame_start(fs_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        logic [6:0] g_hex;
        logic [6:0] g_dec;
    } glyph_rec_t;

    glyph_rec_t gtab [16];

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int cyc      = 0;
    logic [31:0] m_dig = '0;
    logic [7:0]  m_en  = '0;
    logic [7:0]  m_dp  = '0;
    int ff_run = 0;
    int n_fs = 0;
    int prev_fs_cyc = 0;
    bit had_low = 1'b0;
    bit track_blank = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d cyc=%0d)", name, act, exp, t, cyc);
        end
    endtask

    // One clock: sample after the edge, compare with the model, then let the model take its snapshot.
    task automatic cycle();
        int s, slot, phase;
        logic [7:0] exp_an;
        logic [6:0] exp_hh, exp_hd;
        logic exp_dp, exp_fs, en;
        logic [3:0] v;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst) begin
            t = 0; m_dig = '0; m_en = '0; m_dp = '0;
            ff_run = 0; had_low = 1'b0; n_fs = 0;
            chk("rst_an_hex", an_h, 8'hFF);
            chk("rst_an_dec", an_d, 8'hFF);
            chk("rst_hex0_hex", hex_h, 7'h7F);
            chk("rst_hex0_dec", hex_d, 7'h7F);
            chk("rst_dp_hex", dp_h, 1'b1);
            chk("rst_dp_dec", dp_d, 1'b1);
            chk("rst_fs_hex", fs_h, 1'b0);
            chk("rst_fs_dec", fs_d, 1'b0);
        end else begin
            t++;
            s = t - 1;
            slot = (s / PS) % 8;
            phase = s % PS;
            en = m_en[slot];
            v = m_dig[slot*4 +: 4];
            exp_an = (phase >= BC && en) ? ~(8'b1 << slot) : 8'hFF;
            exp_hh = en ? gtab[v].g_hex : 7'h7F;
            exp_hd = en ? gtab[v].g_dec : 7'h7F;
            exp_dp = en ? ~m_dp[slot] : 1'b1;
            exp_fs = (t == 1) || (t % FRAME == 0);
            chk("an_hex", an_h, exp_an);
            chk("an_dec", an_d, exp_an);
            chk("hex0_hex", hex_h, exp_hh);
            chk("hex0_dec", hex_d, exp_hd);
            chk("dp_hex", dp_h, exp_dp);
            chk("dp_dec", dp_d, exp_dp);
            chk("fs_hex", fs_h, exp_fs);
            chk("fs_dec", fs_d, exp_fs);
            if (an_h == 8'hFF) begin
                ff_run++;
            end else begin
                if (track_blank && had_low && ff_run > 0) chk("blank_len", ff_run, BC);
                ff_run = 0;
                had_low = 1'b1;
            end
            if (fs_h) begin
                if (n_fs >= 2) chk("fs_period", cyc - prev_fs_cyc, FRAME);
                prev_fs_cyc = cyc;
                n_fs++;
            end
            if (exp_fs) begin
                m_dig = in_digits;
                m_en  = in_en;
                m_dp  = in_dp;
            end
        end
        chk("an_onehot", 32'($countones(~an_h) <= 1), 1);
    endtask

    initial begin
        int f_change, pos, f, cnt_dp, cnt_even, cnt_odd;
        bit reached;

        gtab[0]  = '{4'h0, 7'b1000000, 7'b1000000};
        gtab[1]  = '{4'h1, 7'b1111001, 7'b1111001};
        gtab[2]  = '{4'h2, 7'b0100100, 7'b0100100};
        gtab[3]  = '{4'h3, 7'b0110000, 7'b0110000};
        gtab[4]  = '{4'h4, 7'b0011001, 7'b0011001};
        gtab[5]  = '{4'h5, 7'b0010010, 7'b0010010};
        gtab[6]  = '{4'h6, 7'b0000010, 7'b0000010};
        gtab[7]  = '{4'h7, 7'b1111000, 7'b1111000};
        gtab[8]  = '{4'h8, 7'b0000000, 7'b0000000};
        gtab[9]  = '{4'h9, 7'b0010000, 7'b0010000};
        gtab[10] = '{4'hA, 7'b0001000, 7'b1111111};
        gtab[11] = '{4'hB, 7'b0000011, 7'b1111111};
        gtab[12] = '{4'hC, 7'b1000110, 7'b1111111};
        gtab[13] = '{4'hD, 7'b0100001, 7'b1111111};
        gtab[14] = '{4'hE, 7'b0000110, 7'b1111111};
        gtab[15] = '{4'hF, 7'b0001110, 7'b1111111};

        // Reset, then release with 76543210 and all digits enabled.
        rst = 1'b1;
        cycle();
        cycle();
        in_digits = 32'h76543210; in_en = 8'hFF; in_dp = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (t == 1)  chk("t1_first_fs", fs_h, 1'b1);
            if (t == 2)  begin chk("t1_an_d0", an_h, 8'hFE); chk("t1_hex_d0", hex_h, 7'b1000000); end
            if (t == 5)  chk("t1_an_gap", an_h, 8'hFF);
            if (t == 6)  begin chk("t1_an_d1", an_h, 8'hFD); chk("t1_hex_d1", hex_h, 7'b1111001); end
            if (t == 30) begin chk("t1_an_d7", an_h, 8'h7F); chk("t1_hex_d7", hex_h, 7'b1111000); end
            if (t == 32) chk("t1_second_fs", fs_h, 1'b1);
        end

        // Change digits while digit 3 is being scanned.
        reached = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            cycle();
            if (((t - 1) / PS) % 8 == 3) reached = 1'b1;
        end
        chk("t2_reach_slot3", reached, 1'b1);
        in_digits = 32'hFEDCBA98;
        f_change = (t - 1) / FRAME;
        for (int i = 0; i < 80; i++) begin
            cycle();
            pos = (t - 1) % FRAME;
            f = (t - 1) / FRAME;
            if (f == f_change && pos == 17) chk("t2_old_d4", hex_h, 7'b0011001);
            if (f == f_change && pos == 29) chk("t2_old_d7", hex_h, 7'b1111000);
            if (f == f_change + 1 && pos == 1) chk("t2_new_d8", hex_h, 7'b0000000);
            if (f == f_change + 1 && pos == 9) begin
                chk("t2_new_A_hex", hex_h, 7'b0001000);
                chk("t2_new_A_dec", hex_d, 7'b1111111);
            end
            if (f == f_change + 1 && pos == 29) begin
                chk("t2_new_F_hex", hex_h, 7'b0001110);
                chk("t2_new_F_dec", hex_d, 7'b1111111);
            end
        end

        // Odd digits only, decimal point requested on a disabled digit.
        in_en = 8'b10101010; in_dp = 8'b00000001;
        reached = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            cycle();
            if (t % FRAME == 0) reached = 1'b1;
        end
        chk("t3_reach_frame", reached, 1'b1);
        cnt_dp = 0; cnt_even = 0; cnt_odd = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (dp_h == 1'b0) cnt_dp++;
            if ((an_h & 8'b01010101) != 8'b01010101) cnt_even++;
            if ((an_h & 8'b10101010) != 8'b10101010) cnt_odd++;
        end
        chk("t3_dp_low_cycles", cnt_dp, 0);
        chk("t3_even_lit_cycles", cnt_even, 0);
        chk("t3_odd_lit_cycles", cnt_odd, 4 * (PS - BC));

        // Decimal point on digit 0, then reset in the middle of slot 5.
        in_en = 8'hFF; in_dp = 8'h01;
        reached = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            cycle();
            if (t % FRAME == 0) reached = 1'b1;
        end
        chk("t4_reach_frame", reached, 1'b1);
        cnt_dp = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if (dp_h == 1'b0) cnt_dp++;
        end
        chk("t4_dp_low_cycles", cnt_dp, PS);
        reached = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            cycle();
            if (((t - 1) / PS) % 8 == 5 && (t - 1) % PS == 1) reached = 1'b1;
        end
        chk("t4_reach_slot5", reached, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (t == 1) chk("t4_refs", fs_h, 1'b1);
            if (t == 2) begin chk("t4_an_d0", an_h, 8'hFE); chk("t4_dp_d0", dp_h, 1'b0); end
        end

        // Glyph table: every value on every digit.
        in_en = 8'hFF; in_dp = 8'h00;
        for (int k = 0; k < 16; k++) begin
            in_digits = {8{gtab[k].val}};
            for (int i = 0; i < FRAME + 8; i++) cycle();
            chk("glyph_hex", hex_h, gtab[k].g_hex);
            chk("glyph_dec", hex_d, gtab[k].g_dec);
        end

        // Long random run with all digits enabled: dead time and frame period stay exact.
        track_blank = 1'b1;
        for (int i = 0; i < 1000 * FRAME; i++) begin
            cycle();
            in_digits = $urandom;
            in_dp = 8'($urandom);
        end
        track_blank = 1'b0;
        for (int i = 0; i < 100 * FRAME; i++) begin
            cycle();
            in_digits = $urandom;
            in_dp = 8'($urandom);
            in_en = 8'($urandom);
        end
        chk("fs_pulses_seen", 32'(n_fs > 1000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
